// File: rtl/nx_rbus_target_pkg.sv
// Shared constants for the rrb block-side target: state encoding, local
// register offsets and the timeout read-data marker.
package nx_rbus_target_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FWD  = 2'd1;
    localparam state_t ST_TMO  = 2'd2;

    localparam logic [15:0] ADDR_ID        = 16'h0000;
    localparam logic [15:0] ADDR_SCRATCH   = 16'h0004;
    localparam logic [15:0] ADDR_INTR_STAT = 16'h0008;
    localparam logic [15:0] ADDR_INTR_MASK = 16'h000C;
    localparam logic [15:0] FWD_BASE       = 16'h0100;

    localparam logic [31:0] TMO_RDATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/nx_rbus_target_if.sv
// Bus bundle between the rrb master and the block target, including the
// user-side register port and the interrupt/ECC sideband.
interface nx_rbus_target_if;
    logic [15:0] rrb_blk_addr;
    logic        rrb_blk_rd_stb;
    logic        rrb_blk_wr_stb;
    logic [31:0] rrb_blk_wr_data;
    logic        blk_rrb_ack;
    logic        blk_rrb_err_ack;
    logic [31:0] blk_rrb_rd_data;
    logic        blk_rrb_intr;
    logic        blk_rrb_ecc_error;
    logic [7:0]  intr_set;
    logic        usr_ecc_err;
    logic [15:0] blk_usr_addr;
    logic        blk_usr_rd;
    logic        blk_usr_wr;
    logic [31:0] blk_usr_wdata;
    logic        usr_blk_ack;
    logic        usr_blk_err;
    logic [31:0] usr_blk_rdata;

    modport slave (
        input  rrb_blk_addr, rrb_blk_rd_stb, rrb_blk_wr_stb, rrb_blk_wr_data,
        input  intr_set, usr_ecc_err, usr_blk_ack, usr_blk_err, usr_blk_rdata,
        output blk_rrb_ack, blk_rrb_err_ack, blk_rrb_rd_data, blk_rrb_intr,
        output blk_rrb_ecc_error, blk_usr_addr, blk_usr_rd, blk_usr_wr, blk_usr_wdata
    );

    modport master (
        output rrb_blk_addr, rrb_blk_rd_stb, rrb_blk_wr_stb, rrb_blk_wr_data,
        output intr_set, usr_ecc_err, usr_blk_ack, usr_blk_err, usr_blk_rdata,
        input  blk_rrb_ack, blk_rrb_err_ack, blk_rrb_rd_data, blk_rrb_intr,
        input  blk_rrb_ecc_error, blk_usr_addr, blk_usr_rd, blk_usr_wr, blk_usr_wdata
    );
endinterface

// File: rtl/nx_rbus_target_regs.sv
// Local register file: ID, SCRATCH, W1C interrupt status with set pulses,
// interrupt mask, combinational read mux and registered interrupt level.
module nx_rbus_target_regs
    import nx_rbus_target_pkg::*;
#(
    parameter logic [31:0] BLK_ID = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr,
    input  logic [7:0]  i_offs,
    input  logic [31:0] i_wdata,
    input  logic [7:0]  i_intr_set,
    output logic [31:0] o_rdata,
    output logic        o_intr
);

    logic [31:0] r_scratch;
    logic [7:0]  r_stat;
    logic [7:0]  r_mask;
    logic        r_intr;
    logic [7:0]  w_stat_clr;

    assign w_stat_clr = (i_wr && (i_offs == ADDR_INTR_STAT[7:0])) ? i_wdata[7:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scratch <= 32'h0;
            r_stat    <= 8'h00;
            r_mask    <= 8'h00;
            r_intr    <= 1'b0;
        end else begin
            if (i_wr && (i_offs == ADDR_SCRATCH[7:0]))
                r_scratch <= i_wdata;
            if (i_wr && (i_offs == ADDR_INTR_MASK[7:0]))
                r_mask <= i_wdata[7:0];
            // OR-ing the set pulses after the clear lets a same-cycle set win.
            r_stat <= (r_stat & ~w_stat_clr) | i_intr_set;
            r_intr <= |(r_stat & r_mask);
        end
    end

    always_comb begin
        o_rdata = 32'h0;
        case (i_offs)
            ADDR_ID[7:0]:        o_rdata = BLK_ID;
            ADDR_SCRATCH[7:0]:   o_rdata = r_scratch;
            ADDR_INTR_STAT[7:0]: o_rdata = {24'h0, r_stat};
            ADDR_INTR_MASK[7:0]: o_rdata = {24'h0, r_mask};
            default:             o_rdata = 32'h0;
        endcase
    end

    assign o_intr = r_intr;

endmodule

// File: rtl/nx_rbus_target.sv
// rrb block target: strobe decode, local/forward dispatch, user-port timeout
// FSM and registered single-pulse responses.
module nx_rbus_target
    import nx_rbus_target_pkg::*;
#(
    parameter logic [31:0] BLK_ID  = 32'h0000_0000,
    parameter int          TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    nx_rbus_target_if.slave   bus
);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_ecc;
    logic [15:0] r_usr_addr;
    logic [31:0] r_usr_wdata;
    logic        r_usr_rd;
    logic        r_usr_wr;

    logic        w_stb;
    logic        w_fwd;
    logic        w_local_ok;
    logic        w_err;
    logic        w_reg_wr;
    logic [31:0] w_reg_rdata;
    logic        w_intr;

    assign w_stb = bus.rrb_blk_rd_stb | bus.rrb_blk_wr_stb;
    assign w_fwd = (bus.rrb_blk_addr >= FWD_BASE);

    assign w_local_ok = ((bus.rrb_blk_addr == ADDR_ID) && !bus.rrb_blk_wr_stb)
                      || (bus.rrb_blk_addr == ADDR_SCRATCH)
                      || (bus.rrb_blk_addr == ADDR_INTR_STAT)
                      || (bus.rrb_blk_addr == ADDR_INTR_MASK);

    assign w_err = (bus.rrb_blk_rd_stb & bus.rrb_blk_wr_stb)
                 | (bus.rrb_blk_addr[1:0] != 2'b00)
                 | (!w_fwd && !w_local_ok);

    // Register writes only happen for accepted, error-free local accesses.
    assign w_reg_wr = (r_state == ST_IDLE) && bus.rrb_blk_wr_stb && !w_err && !w_fwd;

    nx_rbus_target_regs #(
        .BLK_ID (BLK_ID)
    ) u_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (w_reg_wr),
        .i_offs     (bus.rrb_blk_addr[7:0]),
        .i_wdata    (bus.rrb_blk_wr_data),
        .i_intr_set (bus.intr_set),
        .o_rdata    (w_reg_rdata),
        .o_intr     (w_intr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'h0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_ecc       <= 1'b0;
            r_usr_addr  <= 16'h0;
            r_usr_wdata <= 32'h0;
            r_usr_rd    <= 1'b0;
            r_usr_wr    <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            r_usr_rd <= 1'b0;
            r_usr_wr <= 1'b0;
            r_ecc    <= bus.usr_ecc_err;
            case (r_state)
                ST_IDLE: begin
                    if (w_stb) begin
                        if (w_err) begin
                            r_err <= 1'b1;
                        end else if (w_fwd) begin
                            r_usr_addr  <= bus.rrb_blk_addr;
                            r_usr_wdata <= bus.rrb_blk_wr_data;
                            r_usr_rd    <= bus.rrb_blk_rd_stb;
                            r_usr_wr    <= bus.rrb_blk_wr_stb;
                            r_cnt       <= 16'(TIMEOUT - 1);
                            r_state     <= ST_FWD;
                        end else begin
                            r_ack   <= 1'b1;
                            r_rdata <= bus.rrb_blk_rd_stb ? w_reg_rdata : 32'h0;
                        end
                    end
                end
                ST_FWD: begin
                    if (bus.usr_blk_err) begin
                        r_err   <= 1'b1;
                        r_rdata <= bus.usr_blk_rdata;
                        r_state <= ST_IDLE;
                    end else if (bus.usr_blk_ack) begin
                        r_ack   <= 1'b1;
                        r_rdata <= bus.usr_blk_rdata;
                        r_state <= ST_IDLE;
                    end else begin
                        // Leaving one count early lands err_ack exactly TIMEOUT
                        // cycles after the forwarded pulse.
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1)
                            r_state <= ST_TMO;
                    end
                end
                ST_TMO: begin
                    r_err   <= 1'b1;
                    r_rdata <= TMO_RDATA;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.blk_rrb_ack       = r_ack;
    assign bus.blk_rrb_err_ack   = r_err;
    assign bus.blk_rrb_rd_data   = r_rdata;
    assign bus.blk_rrb_intr      = w_intr;
    assign bus.blk_rrb_ecc_error = r_ecc;
    assign bus.blk_usr_addr      = r_usr_addr;
    assign bus.blk_usr_wdata     = r_usr_wdata;
    assign bus.blk_usr_rd        = r_usr_rd;
    assign bus.blk_usr_wr        = r_usr_wr;

endmodule
